// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_pkg
// Purpose  : Shared types and default constants for the two-requester APB
//            round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_t;

    localparam int c_DEF_ADDR_WIDTH = 10;
    localparam int c_DEF_DATA_WIDTH = 32;
    localparam int c_DEF_TIMEOUT    = 16;

    // Width of a counter that must hold 0..t; at least one bit so a
    // disabled timeout (t == 0) still yields a legal vector.
    function automatic int cnt_width(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin pick. A lone requester always wins; when
//            both request, the one that was not granted last wins.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_gnt,
    output logic o_valid,
    output logic o_winner
);

    // Combinational winner select
    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = (i_req0 & i_req1) ? ~i_last_gnt : i_req1;
    end

endmodule
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_rr_arbiter
// Purpose  : Shares one APB bridge port between two requesters with
//            round-robin arbitration, SETUP/ACCESS sequencing, slave select
//            decode from the address MSB and a bounded ACCESS timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
    parameter int TIMEOUT    = c_DEF_TIMEOUT
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  REQ_0,
    input  logic                  REQ_1,
    input  logic                  WR_0,
    input  logic                  WR_1,
    input  logic [ADDR_WIDTH-1:0] ADDR_0,
    input  logic [ADDR_WIDTH-1:0] ADDR_1,
    input  logic [DATA_WIDTH-1:0] WDATA_0,
    input  logic [DATA_WIDTH-1:0] WDATA_1,
    output logic                  GNT_0,
    output logic                  GNT_1,
    output logic                  DONE_0,
    output logic                  DONE_1,
    output logic                  ERR,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  PSEL_1,
    output logic                  PSEL_2,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY
);

    localparam int                 c_CNT_W    = cnt_width(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    // Registered state and outputs. PWRITE/PADDR/PWDATA double as the
    // captured request payload, so later payload changes cannot leak in.
    state_t                r_state;
    logic                  r_owner;
    logic                  r_last_gnt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_gnt0, r_gnt1, r_done0, r_done1, r_err;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_psel1, r_psel2, r_penable, r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;

    state_t                w_state_nxt;
    logic                  w_owner_nxt, w_last_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic                  w_gnt0_nxt, w_gnt1_nxt, w_done0_nxt, w_done1_nxt, w_err_nxt;
    logic [DATA_WIDTH-1:0] w_rdata_nxt;
    logic                  w_psel1_nxt, w_psel2_nxt, w_penable_nxt, w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [DATA_WIDTH-1:0] w_pwdata_nxt;

    logic                  w_arb_valid;
    logic                  w_arb_winner;
    logic [ADDR_WIDTH-1:0] w_win_addr;
    logic                  w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_req0     (REQ_0),
        .i_req1     (REQ_1),
        .i_last_gnt (r_last_gnt),
        .o_valid    (w_arb_valid),
        .o_winner   (w_arb_winner)
    );

    // Next-state and next-output computation for the transfer sequencer
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last_gnt;
        w_cnt_nxt     = r_cnt;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_done0_nxt   = 1'b0;
        w_done1_nxt   = 1'b0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = '0;
        w_psel1_nxt   = r_psel1;
        w_psel2_nxt   = r_psel2;
        w_penable_nxt = 1'b0;
        w_pwrite_nxt  = r_pwrite;
        w_paddr_nxt   = r_paddr;
        w_pwdata_nxt  = r_pwdata;
        w_win_addr    = w_arb_winner ? ADDR_1 : ADDR_0;
        w_timeout     = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_state_nxt  = SETUP;
                    w_owner_nxt  = w_arb_winner;
                    w_gnt0_nxt   = ~w_arb_winner;
                    w_gnt1_nxt   = w_arb_winner;
                    w_psel1_nxt  = ~w_win_addr[ADDR_WIDTH-1];
                    w_psel2_nxt  = w_win_addr[ADDR_WIDTH-1];
                    w_pwrite_nxt = w_arb_winner ? WR_1 : WR_0;
                    w_paddr_nxt  = w_win_addr;
                    w_pwdata_nxt = w_arb_winner ? WDATA_1 : WDATA_0;
                end
            end
            SETUP: begin
                w_state_nxt   = ACCESS;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end
            ACCESS: begin
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                // PREADY is checked first so a ready on the last allowed
                // cycle still completes normally.
                if (PREADY || w_timeout) begin
                    w_state_nxt   = RESP;
                    w_done0_nxt   = ~r_owner;
                    w_done1_nxt   = r_owner;
                    w_err_nxt     = ~PREADY;
                    w_rdata_nxt   = (PREADY && !r_pwrite) ? PRDATA : '0;
                    w_psel1_nxt   = 1'b0;
                    w_psel2_nxt   = 1'b0;
                    w_penable_nxt = 1'b0;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
                w_last_nxt  = r_owner;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer silently
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_cnt      <= '0;
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_psel1    <= 1'b0;
            r_psel2    <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_last_gnt <= w_last_nxt;
            r_cnt      <= w_cnt_nxt;
            r_gnt0     <= w_gnt0_nxt;
            r_gnt1     <= w_gnt1_nxt;
            r_done0    <= w_done0_nxt;
            r_done1    <= w_done1_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            r_psel1    <= w_psel1_nxt;
            r_psel2    <= w_psel2_nxt;
            r_penable  <= w_penable_nxt;
            r_pwrite   <= w_pwrite_nxt;
            r_paddr    <= w_paddr_nxt;
            r_pwdata   <= w_pwdata_nxt;
        end
    end

    assign GNT_0   = r_gnt0;
    assign GNT_1   = r_gnt1;
    assign DONE_0  = r_done0;
    assign DONE_1  = r_done1;
    assign ERR     = r_err;
    assign RDATA   = r_rdata;
    assign PSEL_1  = r_psel1;
    assign PSEL_2  = r_psel2;
    assign PENABLE = r_penable;
    assign PWRITE  = r_pwrite;
    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_rr_arbiter
// Purpose  : Self-checking bench for apb_rr_arbiter: transfer-level timeline
//            model compared every cycle, plus literal checks of key results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_rr_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK, PRESET;
    logic          REQ_0, REQ_1, WR_0, WR_1;
    logic [AW-1:0] ADDR_0, ADDR_1;
    logic [DW-1:0] WDATA_0, WDATA_1;
    logic          GNT_0, GNT_1, DONE_0, DONE_1, ERR;
    logic [DW-1:0] RDATA;
    logic          PSEL_1, PSEL_2, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic          PREADY;

    apb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .REQ_0(REQ_0), .REQ_1(REQ_1), .WR_0(WR_0), .WR_1(WR_1),
        .ADDR_0(ADDR_0), .ADDR_1(ADDR_1), .WDATA_0(WDATA_0), .WDATA_1(WDATA_1),
        .GNT_0(GNT_0), .GNT_1(GNT_1), .DONE_0(DONE_0), .DONE_1(DONE_1),
        .ERR(ERR), .RDATA(RDATA), .PSEL_1(PSEL_1), .PSEL_2(PSEL_2),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Bridge behaviour knobs: PREADY rises on ACCESS cycle number ready_lat
    // (0 = never).
    int            ready_lat = 1;
    logic [DW-1:0] rd_val    = '0;
    int            acc_n     = 0;

    // Event log filled by the compare process
    logic          gnt_q[$];
    int            gnt_cyc_q[$];
    int            gnt_cyc   = 0;
    int            done_cyc  = 0;
    int            done_cnt  = 0;
    logic          done_who  = 1'b0;
    logic          done_err  = 1'b0;
    logic [DW-1:0] done_rdata = '0;

    // Transfer timeline model: m_t is the cycle index inside a transfer
    // (0 = idle, 1 = grant cycle, 2.. = access cycles); m_end is the last
    // access cycle index once known, and the completion cycle is m_end+1.
    int            m_t      = 0;
    int            m_end    = 0;
    logic          m_last   = 1'b1;
    logic          m_owner  = 1'b0;
    logic          m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic          m_err    = 1'b0;
    logic [DW-1:0] m_rdata  = '0;

    logic e_gnt, e_acc, e_psel, e_done;

    function automatic logic pick(input logic r0, input logic r1, input logic last);
        return (r0 && r1) ? !last : r1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_GNT_0"},   64'(GNT_0),   64'd0);
        chk({pfx, "_GNT_1"},   64'(GNT_1),   64'd0);
        chk({pfx, "_DONE_0"},  64'(DONE_0),  64'd0);
        chk({pfx, "_DONE_1"},  64'(DONE_1),  64'd0);
        chk({pfx, "_ERR"},     64'(ERR),     64'd0);
        chk({pfx, "_RDATA"},   64'(RDATA),   64'd0);
        chk({pfx, "_PSEL_1"},  64'(PSEL_1),  64'd0);
        chk({pfx, "_PSEL_2"},  64'(PSEL_2),  64'd0);
        chk({pfx, "_PENABLE"}, 64'(PENABLE), 64'd0);
        chk({pfx, "_PWRITE"},  64'(PWRITE),  64'd0);
        chk({pfx, "_PADDR"},   64'(PADDR),   64'd0);
        chk({pfx, "_PWDATA"},  64'(PWDATA),  64'd0);
    endtask

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial forever begin
        @(posedge PCLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    // Model advances on the same edges the DUT samples its inputs
    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_t    <= 0;
            m_end  <= 0;
            m_last <= 1'b1;
        end else if (m_t == 0) begin
            if (REQ_0 || REQ_1) begin
                m_owner <= pick(REQ_0, REQ_1, m_last);
                m_wr    <= pick(REQ_0, REQ_1, m_last) ? WR_1    : WR_0;
                m_addr  <= pick(REQ_0, REQ_1, m_last) ? ADDR_1  : ADDR_0;
                m_wdata <= pick(REQ_0, REQ_1, m_last) ? WDATA_1 : WDATA_0;
                m_t     <= 1;
                m_end   <= 0;
            end
        end else if (m_end == 0 && m_t >= 2 && (PREADY || (TO != 0 && m_t - 1 == TO))) begin
            m_end   <= m_t;
            m_err   <= !PREADY;
            m_rdata <= (PREADY && !m_wr) ? PRDATA : '0;
            m_t     <= m_t + 1;
        end else if (m_end != 0 && m_t == m_end + 1) begin
            m_t    <= 0;
            m_end  <= 0;
            m_last <= m_owner;
        end else begin
            m_t <= m_t + 1;
        end
    end

    // Per-cycle comparison against the model, plus event logging
    initial forever begin
        @(negedge PCLK);
        e_gnt  = (m_t == 1);
        e_acc  = (m_t >= 2) && (m_end == 0);
        e_psel = e_gnt || e_acc;
        e_done = (m_end != 0) && (m_t == m_end + 1);
        chk("GNT_0",   64'(GNT_0),   64'(e_gnt && !m_owner));
        chk("GNT_1",   64'(GNT_1),   64'(e_gnt && m_owner));
        chk("DONE_0",  64'(DONE_0),  64'(e_done && !m_owner));
        chk("DONE_1",  64'(DONE_1),  64'(e_done && m_owner));
        chk("PSEL_1",  64'(PSEL_1),  64'(e_psel && !m_addr[AW-1]));
        chk("PSEL_2",  64'(PSEL_2),  64'(e_psel && m_addr[AW-1]));
        chk("PENABLE", 64'(PENABLE), 64'(e_acc));
        if (e_psel) begin
            chk("PWRITE", 64'(PWRITE), 64'(m_wr));
            chk("PADDR",  64'(PADDR),  64'(m_addr));
            if (m_wr) chk("PWDATA", 64'(PWDATA), 64'(m_wdata));
        end
        if (e_done) begin
            chk("ERR",   64'(ERR),   64'(m_err));
            chk("RDATA", 64'(RDATA), 64'(m_rdata));
        end
        if (GNT_0 || GNT_1) begin
            gnt_q.push_back(GNT_1);
            gnt_cyc_q.push_back(cyc);
            gnt_cyc = cyc;
        end
        if (DONE_0 || DONE_1) begin
            done_cnt++;
            done_cyc   = cyc;
            done_who   = DONE_1;
            done_err   = ERR;
            done_rdata = RDATA;
        end
    end

    // Bridge responder: counts ACCESS cycles and raises PREADY on cue
    initial begin
        PREADY = 1'b0;
        PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PRESET || !(PSEL_1 || PSEL_2) || !PENABLE) begin
                acc_n  = 0;
                PREADY = 1'b0;
            end else begin
                acc_n++;
                PREADY = (ready_lat != 0) && (acc_n == ready_lat);
                PRDATA = PREADY ? rd_val : (32'h5A5A_0000 + DW'(acc_n));
            end
        end
    end

    // kind 0: wait for a grant, kind 1: wait for a completion
    task automatic wait_evt(input int kind, input string nm);
        int  n   = 0;
        bit  hit = 0;
        while (!hit && n < 60) begin
            @(negedge PCLK);
            hit = (kind == 0) ? (GNT_0 || GNT_1) : (DONE_0 || DONE_1);
            n++;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: no event within 60 cycles, required one", nm);
        end
        #1;
    endtask

    // One requester-driven transfer; payload is scrambled after the grant
    task automatic do_xfer(input logic who, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rv,
                           input string nm);
        ready_lat = lat;
        rd_val    = rv;
        @(posedge PCLK);
        #1;
        if (who) begin
            REQ_1 = 1'b1; WR_1 = wr; ADDR_1 = a; WDATA_1 = wd;
        end else begin
            REQ_0 = 1'b1; WR_0 = wr; ADDR_0 = a; WDATA_0 = wd;
        end
        wait_evt(0, {nm, "_gnt_wait"});
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        ADDR_0 = ~a; ADDR_1 = ~a; WDATA_0 = ~wd; WDATA_1 = ~wd; WR_0 = ~wr; WR_1 = ~wr;
        wait_evt(1, {nm, "_done_wait"});
    endtask

    int base;
    int n;
    int done_before;

    initial begin
        PRESET = 1'b1;
        REQ_0 = 1'b0; REQ_1 = 1'b0; WR_0 = 1'b0; WR_1 = 1'b0;
        ADDR_0 = '0; ADDR_1 = '0; WDATA_0 = '0; WDATA_1 = '0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk_all_zero("rst");
        @(posedge PCLK);
        #1 PRESET = 1'b0;

        // Single read from slave 1, PREADY on the 2nd ACCESS cycle
        do_xfer(1'b0, 1'b0, 10'h004, 32'h0, 2, 32'hDEADBEEF, "rd");
        chk("rd_who",     64'(done_who),           64'd0);
        chk("rd_rdata",   64'(done_rdata),         64'hDEADBEEF);
        chk("rd_err",     64'(done_err),           64'd0);
        chk("rd_latency", 64'(done_cyc - gnt_cyc), 64'd3);

        // Write to slave 2, read data must be ignored
        do_xfer(1'b1, 1'b1, 10'h200, 32'h12345678, 1, 32'hAAAA5555, "wr");
        chk("wr_who",   64'(done_who),   64'd1);
        chk("wr_rdata", 64'(done_rdata), 64'd0);
        chk("wr_err",   64'(done_err),   64'd0);

        // Contention: both held for four grants, PREADY immediate
        ready_lat = 1;
        rd_val    = 32'h0F0F_1234;
        @(posedge PCLK);
        #1;
        REQ_0 = 1'b1; WR_0 = 1'b0; ADDR_0 = 10'h020; WDATA_0 = 32'h0;
        REQ_1 = 1'b1; WR_1 = 1'b1; ADDR_1 = 10'h300; WDATA_1 = 32'h0BADF00D;
        base = gnt_q.size();
        n = 0;
        while (gnt_q.size() < base + 4 && n < 100) begin
            @(negedge PCLK);
            #1;
            n++;
        end
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        if (gnt_q.size() < base + 4) begin
            total++;
            bad++;
            $display("FAIL cont_grants: got %0d grants, required 4", gnt_q.size() - base);
        end else begin
            chk("cont_g0",      64'(gnt_q[base]),     64'd0);
            chk("cont_g1",      64'(gnt_q[base + 1]), 64'd1);
            chk("cont_g2",      64'(gnt_q[base + 2]), 64'd0);
            chk("cont_g3",      64'(gnt_q[base + 3]), 64'd1);
            chk("cont_spacing", 64'(gnt_cyc_q[base + 3] - gnt_cyc_q[base]), 64'd12);
        end
        wait_evt(1, "cont_done_wait");

        // Timeout: PREADY never rises
        do_xfer(1'b1, 1'b0, 10'h010, 32'h0, 0, 32'h11112222, "to");
        chk("to_err",     64'(done_err),           64'd1);
        chk("to_rdata",   64'(done_rdata),         64'd0);
        chk("to_latency", 64'(done_cyc - gnt_cyc), 64'd17);

        // PREADY on the last allowed ACCESS cycle wins over the timeout
        do_xfer(1'b0, 1'b0, 10'h3F0, 32'h0, 16, 32'hCAFEF00D, "edge");
        chk("edge_err",     64'(done_err),           64'd0);
        chk("edge_rdata",   64'(done_rdata),         64'hCAFEF00D);
        chk("edge_latency", 64'(done_cyc - gnt_cyc), 64'd17);

        // Async reset in the middle of ACCESS
        ready_lat = 0;
        @(posedge PCLK);
        #1;
        REQ_1 = 1'b1; WR_1 = 1'b0; ADDR_1 = 10'h044;
        wait_evt(0, "arst_gnt_wait");
        REQ_1 = 1'b0;
        done_before = done_cnt;
        repeat (3) @(posedge PCLK);
        #1;
        chk("arst_pre_penable", 64'(PENABLE), 64'd1);
        PRESET = 1'b1;
        #1;
        chk_all_zero("arst");
        repeat (2) @(posedge PCLK);
        #1 PRESET = 1'b0;
        chk("arst_no_done", 64'(done_cnt), 64'(done_before));

        // After reset, simultaneous requests favour requester 0
        ready_lat = 1;
        rd_val    = 32'h7777_8888;
        @(posedge PCLK);
        #1;
        REQ_0 = 1'b1; WR_0 = 1'b0; ADDR_0 = 10'h008;
        REQ_1 = 1'b1; WR_1 = 1'b0; ADDR_1 = 10'h208;
        wait_evt(0, "post_rst_gnt_wait");
        REQ_0 = 1'b0; REQ_1 = 1'b0;
        chk("post_rst_gnt0", 64'(GNT_0), 64'd1);
        wait_evt(1, "post_rst_done_wait");
        chk("post_rst_who",   64'(done_who),   64'd0);
        chk("post_rst_rdata", 64'(done_rdata), 64'h7777_8888);

        repeat (3) @(posedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Shares the single APB bridge upstream port between two independent requesters (REQ_0, REQ_1) using round-robin arbitration.
- Sequences each granted request through a standard APB SETUP/ACCESS handshake on the bridge.
- Decodes the target slave select (PSEL_1/PSEL_2) from the address MSB.
- Returns read data and completion/error status to the owning requester, with a bounded wait timeout.

Parameters:
- ADDR_WIDTH, 10: requester and APB address width.
- DATA_WIDTH, 32: read/write data width.
- TIMEOUT, 16: maximum ACCESS cycles before abort; 0 disables the timeout.

Ports:
- PCLK  input  1  clock, all logic on rising edge
- PRESET  input  1  reset, asynchronous, active-high
- REQ_0 / REQ_1  input  1  transfer request, requester 0/1
- WR_0 / WR_1  input  1  1=write, 0=read
- ADDR_0 / ADDR_1  input  ADDR_WIDTH  transfer address
- WDATA_0 / WDATA_1  input  DATA_WIDTH  write data
- GNT_0 / GNT_1  output  1  one-cycle pulse: request captured
- DONE_0 / DONE_1  output  1  one-cycle pulse: transfer finished
- ERR  output  1  valid with DONE_x: 1 = timeout abort
- RDATA  output  DATA_WIDTH  valid with DONE_x
- PSEL_1 / PSEL_2  output  1  slave selects to bridge
- PENABLE  output  1  APB enable to bridge
- PWRITE  output  1  APB direction to bridge
- PADDR  output  ADDR_WIDTH  APB address to bridge
- PWDATA  output  DATA_WIDTH  APB write data to bridge
- PRDATA  input  DATA_WIDTH  read data from bridge
- PREADY  input  1  transfer complete from bridge

Behaviour:
- All outputs are registered.
- PRESET (async, active-high) forces: state IDLE, every output 0, timeout counter 0, round-robin pointer last_gnt=1 (requester 0 favoured next).
- Reset mid-transfer aborts silently: no DONE or ERR is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any REQ_x is sampled high, pick the winner. With a single requester, it wins. With both, the one not equal to last_gnt wins.
  - Latch the winner's WR/ADDR/WDATA, then transition to SETUP.
  - If no request, remain in IDLE.
- SETUP (exactly 1 cycle):
  - GNT_winner=1.
  - PSEL_1=1 if latched ADDR[ADDR_WIDTH-1]==0, else PSEL_2=1.
  - PENABLE=0; PWRITE/PADDR/PWDATA driven from the latch.
  - Transition to ACCESS; timeout counter cleared.
- ACCESS:
  - PSEL held, PENABLE=1, counter increments each cycle.
  - PREADY=1 sampled → RESP with ERR=0. For a read, RDATA<=PRDATA; for a write, RDATA<=0.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1 → RESP with ERR=1, RDATA=0.
  - If PREADY and timeout coincide, PREADY wins.
- RESP (1 cycle):
  - DONE_winner=1, ERR/RDATA valid.
  - PSEL_x=0, PENABLE=0.
  - last_gnt<=winner; transition to IDLE.
- Latency:
  - REQ sampled at edge N → GNT/PSEL visible in cycle N+1 → PENABLE in N+2.
  - DONE appears one cycle after the PREADY sample.
  - Minimum 4 cycles per transfer, including one IDLE gap with PSEL low between back-to-back transfers.
- Requester rule:
  - Hold REQ and payload stable until GNT, then drop REQ during the GNT cycle.
  - REQ still high when IDLE is re-entered is treated as a new request.
  - Payload changes after GNT are ignored.
- Only one of GNT_0/GNT_1, one of DONE_0/DONE_1, and one of PSEL_1/PSEL_2 is ever high.
- Timeout counter width is clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package apb_arb_pkg holds: state enum (IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10, RESP=2'b11) and default width/timeout constants.
- One sub-module, rr_arb2: 2-way round-robin pick from {req0, req1, last_gnt}, giving a combinational winner and valid.

Test Plan:
- Single read: REQ_0, ADDR_0=10'h004, PREADY after 2 ACCESS cycles with PRDATA=32'hDEADBEEF → GNT_0 pulse; PSEL_1=1; DONE_0 with RDATA=32'hDEADBEEF, ERR=0.
- Write to slave 2: REQ_1, WR_1=1, ADDR_1=10'h200, WDATA_1=32'h12345678 → PSEL_2=1, PWRITE=1, PWDATA=32'h12345678; DONE_1, RDATA=0.
- Contention: REQ_0 and REQ_1 both held for 4 transfers, PREADY immediate → grants alternate 0,1,0,1, with a PSEL-low cycle between each.
- Timeout: TIMEOUT=16, PREADY held 0 → exactly 16 ACCESS cycles, then DONE_x with ERR=1, RDATA=0; PSEL drops in the RESP cycle.
- PREADY asserted on the 16th ACCESS cycle → ERR=0 and data returned.
- Async reset asserted mid-ACCESS → all outputs 0 immediately with no DONE; after release, the next simultaneous request grants requester 0.
